// File: rtl/count_seq_monitor_if.sv
// Bundles the sampled counter inputs and the registered status outputs of
// count_seq_monitor. The master side (counter plus status logic) drives the
// inputs; the slave side is the monitor itself.
interface count_seq_monitor_if #(
  parameter int CW     = 4,
  parameter int WRAP_W = 8
);
  logic              en;
  logic [CW-1:0]     count_in;
  logic [CW-1:0]     match_val;
  logic              clr_wrap;
  logic              wrap_pulse;
  logic              match_pulse;
  logic              jump_pulse;
  logic [CW-1:0]     jump_val;
  logic [WRAP_W-1:0] wrap_cnt;
  logic              wrap_sat;
  logic              stall;

  modport master (
    output en, count_in, match_val, clr_wrap,
    input  wrap_pulse, match_pulse, jump_pulse, jump_val, wrap_cnt, wrap_sat, stall
  );

  modport slave (
    input  en, count_in, match_val, clr_wrap,
    output wrap_pulse, match_pulse, jump_pulse, jump_val, wrap_cnt, wrap_sat, stall
  );
endinterface

// File: rtl/count_seq_monitor.sv
// count_seq_monitor: watches a free-running counter and classifies each
// enabled transition as step, hold, wrap or jump. It reports wrap, match and
// jump pulses, a saturating wrap tally with a sticky overflow flag, and a
// stall level that is raised after STALL_LIM consecutive holds.
// Every output is registered, so a sample taken at edge N is visible from
// edge N until edge N+1.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | no valid previous sample; next enabled cycle only captures
// TRACK   | previous sample valid; each enabled cycle is classified
// STALLED | count held STALL_LIM cycles; stall asserted until it moves
module count_seq_monitor #(
  parameter int CW        = 4,
  parameter int WRAP_W    = 8,
  parameter int STALL_LIM = 15
) (
  input  logic                clk,
  input  logic                reset,
  count_seq_monitor_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    TRACK   = 2'd1,
    STALLED = 2'd2
  } state_t;

  localparam logic [CW-1:0]     MAXV     = '1;
  localparam logic [WRAP_W-1:0] WRAP_MAX = '1;
  localparam logic [7:0]        HOLD_LIM = 8'(STALL_LIM);

  state_t            state_q, state_d;
  logic [CW-1:0]     prev_q, prev_d;
  logic [7:0]        hold_ctr_q, hold_ctr_d;
  logic              wrap_pulse_q, wrap_pulse_d;
  logic              match_pulse_q, match_pulse_d;
  logic              jump_pulse_q, jump_pulse_d;
  logic [CW-1:0]     jump_val_q, jump_val_d;
  logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;
  logic              wrap_sat_q, wrap_sat_d;
  logic              stall_q, stall_d;

  logic is_wrap;
  logic is_step;
  logic is_hold;
  logic is_match;
  logic wrap_evt;

  // Transition class of the current sample against the previous one.
  always_comb begin
    is_wrap  = (prev_q == MAXV) && (bus.count_in == '0);
    is_step  = (bus.count_in == prev_q + CW'(1));
    is_hold  = (bus.count_in == prev_q);
    is_match = (bus.count_in == bus.match_val);
  end

  // Next-state, classification and output computation.
  always_comb begin
    state_d       = state_q;
    prev_d        = prev_q;
    hold_ctr_d    = hold_ctr_q;
    wrap_pulse_d  = 1'b0;
    match_pulse_d = 1'b0;
    jump_pulse_d  = 1'b0;
    jump_val_d    = jump_val_q;
    wrap_cnt_d    = wrap_cnt_q;
    wrap_sat_d    = wrap_sat_q;
    stall_d       = stall_q;
    wrap_evt      = 1'b0;

    if (!bus.en) begin
      state_d    = IDLE;
      hold_ctr_d = '0;
      stall_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          prev_d     = bus.count_in;
          hold_ctr_d = '0;
          stall_d    = 1'b0;
          state_d    = TRACK;
        end

        TRACK, STALLED: begin
          if (is_hold && !is_wrap && state_q == STALLED) begin
            // Still held: stall stays up and the hold count rests at the limit.
            stall_d = 1'b1;
          end else begin
            prev_d     = bus.count_in;
            hold_ctr_d = '0;
            stall_d    = 1'b0;
            state_d    = TRACK;
            if (is_wrap) begin
              wrap_evt      = 1'b1;
              wrap_pulse_d  = 1'b1;
              match_pulse_d = is_match;
            end else if (is_step) begin
              match_pulse_d = is_match;
            end else if (is_hold) begin
              hold_ctr_d = hold_ctr_q + 8'd1;
              if (hold_ctr_d == HOLD_LIM) begin
                state_d = STALLED;
                stall_d = 1'b1;
              end
            end else begin
              jump_pulse_d  = 1'b1;
              jump_val_d    = bus.count_in;
              match_pulse_d = is_match;
            end
          end
        end

        default: begin
          state_d    = IDLE;
          hold_ctr_d = '0;
          stall_d    = 1'b0;
        end
      endcase
    end

    // A clear coincident with a wrap counts that wrap after clearing.
    if (bus.clr_wrap) begin
      wrap_cnt_d = wrap_evt ? WRAP_W'(1) : '0;
      wrap_sat_d = 1'b0;
    end else if (wrap_evt) begin
      if (wrap_cnt_q == WRAP_MAX) begin
        wrap_sat_d = 1'b1;
      end else begin
        wrap_cnt_d = wrap_cnt_q + WRAP_W'(1);
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      prev_q        <= '0;
      hold_ctr_q    <= '0;
      wrap_pulse_q  <= 1'b0;
      match_pulse_q <= 1'b0;
      jump_pulse_q  <= 1'b0;
      jump_val_q    <= '0;
      wrap_cnt_q    <= '0;
      wrap_sat_q    <= 1'b0;
      stall_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      prev_q        <= prev_d;
      hold_ctr_q    <= hold_ctr_d;
      wrap_pulse_q  <= wrap_pulse_d;
      match_pulse_q <= match_pulse_d;
      jump_pulse_q  <= jump_pulse_d;
      jump_val_q    <= jump_val_d;
      wrap_cnt_q    <= wrap_cnt_d;
      wrap_sat_q    <= wrap_sat_d;
      stall_q       <= stall_d;
    end
  end

  // Registered outputs onto the interface.
  always_comb begin
    bus.wrap_pulse  = wrap_pulse_q;
    bus.match_pulse = match_pulse_q;
    bus.jump_pulse  = jump_pulse_q;
    bus.jump_val    = jump_val_q;
    bus.wrap_cnt    = wrap_cnt_q;
    bus.wrap_sat    = wrap_sat_q;
    bus.stall       = stall_q;
  end

endmodule

// File: tb/tb_count_seq_monitor.sv
// Directed bench for count_seq_monitor: a vector table for the main sequences
// plus hand-written runs for saturation, clear-on-wrap and reset-in-stall.
module tb_count_seq_monitor;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  count_seq_monitor_if #(.CW(4), .WRAP_W(8)) bus ();

  count_seq_monitor #(.CW(4), .WRAP_W(8), .STALL_LIM(15)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Expected-output layout: {wrap, match, jump, jump_val[3:0], wrap_cnt[7:0], sat, stall}
  typedef struct {
    logic        en;
    logic [3:0]  cin;
    logic [3:0]  mv;
    logic        clr;
    logic [16:0] exp;
  } vec_t;

  vec_t vecs[64];
  int   nvec = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [16:0] ex(input logic wp, input logic mp, input logic jp,
                                     input logic [3:0] jv, input logic [7:0] wc,
                                     input logic ws, input logic st);
    return {wp, mp, jp, jv, wc, ws, st};
  endfunction

  function automatic logic [16:0] got();
    return {bus.wrap_pulse, bus.match_pulse, bus.jump_pulse, bus.jump_val,
            bus.wrap_cnt, bus.wrap_sat, bus.stall};
  endfunction

  task automatic add(input logic en, input logic [3:0] cin, input logic [3:0] mv,
                     input logic clr, input logic [16:0] e);
    vecs[nvec].en  = en;
    vecs[nvec].cin = cin;
    vecs[nvec].mv  = mv;
    vecs[nvec].clr = clr;
    vecs[nvec].exp = e;
    nvec++;
  endtask

  task automatic check(input string name, input logic [16:0] e);
    logic [16:0] g;
    g = got();
    n_cmp++;
    if (g !== e) begin
      n_bad++;
      $display("FAIL %s: got {wp,mp,jp,jv,wc,sat,st}=%b_%b_%b_%h_%h_%b_%b required %b_%b_%b_%h_%h_%b_%b",
               name, g[16], g[15], g[14], g[13:10], g[9:2], g[1], g[0],
               e[16], e[15], e[14], e[13:10], e[9:2], e[1], e[0]);
    end
  endtask

  task automatic cyc(input logic en, input logic [3:0] cin, input logic [3:0] mv,
                     input logic clr);
    @(negedge clk);
    bus.en        = en;
    bus.count_in  = cin;
    bus.match_val = mv;
    bus.clr_wrap  = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset        = 1'b1;
    bus.en       = 1'b0;
    bus.clr_wrap = 1'b0;
    @(posedge clk);
    #1;
    check("reset", ex(0, 0, 0, 4'h0, 8'd0, 0, 0));
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    bus.en = 1'b0; bus.count_in = '0; bus.match_val = '0; bus.clr_wrap = 1'b0;

    // 1: full count with one wrap, match_val=5
    add(1, 4'd0, 4'd5, 0, ex(0, 0, 0, 4'h0, 8'd0, 0, 0));
    for (int c = 1; c <= 15; c++)
      add(1, 4'(c), 4'd5, 0, ex(0, (c == 5), 0, 4'h0, 8'd0, 0, 0));
    add(1, 4'd0, 4'd5, 0, ex(1, 0, 0, 4'h0, 8'd1, 0, 0));
    add(1, 4'd1, 4'd5, 0, ex(0, 0, 0, 4'h0, 8'd1, 0, 0));
    // 2: 3,4,9,10 after re-capture -> one jump to 9
    add(0, 4'd0, 4'd5, 0, ex(0, 0, 0, 4'h0, 8'd1, 0, 0));
    add(1, 4'd3, 4'd5, 0, ex(0, 0, 0, 4'h0, 8'd1, 0, 0));
    add(1, 4'd4, 4'd5, 0, ex(0, 0, 0, 4'h0, 8'd1, 0, 0));
    add(1, 4'd9, 4'd5, 0, ex(0, 0, 1, 4'h9, 8'd1, 0, 0));
    add(1, 4'd10, 4'd5, 0, ex(0, 0, 0, 4'h9, 8'd1, 0, 0));
    // 3: hold 7 for 15 cycles -> stall, then step to 8
    add(0, 4'd0, 4'd5, 0, ex(0, 0, 0, 4'h9, 8'd1, 0, 0));
    add(1, 4'd7, 4'd5, 0, ex(0, 0, 0, 4'h9, 8'd1, 0, 0));
    for (int h = 1; h <= 15; h++)
      add(1, 4'd7, 4'd5, 0, ex(0, 0, 0, 4'h9, 8'd1, 0, (h == 15)));
    add(1, 4'd7, 4'd5, 0, ex(0, 0, 0, 4'h9, 8'd1, 0, 1));
    add(1, 4'd7, 4'd5, 0, ex(0, 0, 0, 4'h9, 8'd1, 0, 1));
    add(1, 4'd8, 4'd5, 0, ex(0, 0, 0, 4'h9, 8'd1, 0, 0));
    // 5: en dropped at 6, re-enabled at 12 -> quiet capture, then step 12->13
    add(0, 4'd0, 4'd5, 0, ex(0, 0, 0, 4'h9, 8'd1, 0, 0));
    add(1, 4'd5, 4'd5, 0, ex(0, 0, 0, 4'h9, 8'd1, 0, 0));
    add(1, 4'd6, 4'd5, 0, ex(0, 0, 0, 4'h9, 8'd1, 0, 0));
    add(0, 4'd6, 4'd5, 0, ex(0, 0, 0, 4'h9, 8'd1, 0, 0));
    add(0, 4'd9, 4'd5, 0, ex(0, 0, 0, 4'h9, 8'd1, 0, 0));
    add(1, 4'd12, 4'd12, 0, ex(0, 0, 0, 4'h9, 8'd1, 0, 0));
    add(1, 4'd13, 4'd13, 0, ex(0, 1, 0, 4'h9, 8'd1, 0, 0));

    repeat (2) @(posedge clk);
    do_reset();
    for (int i = 0; i < nvec; i++) begin
      cyc(vecs[i].en, vecs[i].cin, vecs[i].mv, vecs[i].clr);
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // 4: wrap saturation, then clear coincident with a wrap
    do_reset();
    cyc(1, 4'd15, 4'd3, 0);
    check("sat_capture", ex(0, 0, 0, 4'h0, 8'd0, 0, 0));
    for (int k = 1; k <= 256; k++) begin
      cyc(1, 4'd0, 4'd3, 0);
      check($sformatf("sat_wrap%0d", k),
            ex(1, 0, 0, (k == 1) ? 4'h0 : 4'hf, (k >= 255) ? 8'd255 : 8'(k), (k == 256), 0));
      cyc(1, 4'd15, 4'd3, 0);
      check($sformatf("sat_jump%0d", k),
            ex(0, 0, 1, 4'hf, (k >= 255) ? 8'd255 : 8'(k), (k == 256), 0));
    end
    cyc(1, 4'd0, 4'd3, 1);
    check("clr_with_wrap", ex(1, 0, 0, 4'hf, 8'd1, 0, 0));
    cyc(1, 4'd1, 4'd3, 1);
    check("clr_no_wrap", ex(0, 0, 0, 4'hf, 8'd0, 0, 0));

    // 6: reset while stalled with wrap_cnt=4
    do_reset();
    cyc(1, 4'd15, 4'd3, 0);
    for (int k = 0; k < 3; k++) begin
      cyc(1, 4'd0, 4'd3, 0);
      cyc(1, 4'd15, 4'd3, 0);
    end
    cyc(1, 4'd0, 4'd3, 0);
    check("four_wraps", ex(1, 0, 0, 4'hf, 8'd4, 0, 0));
    repeat (14) cyc(1, 4'd0, 4'd3, 0);
    check("hold14", ex(0, 0, 0, 4'hf, 8'd4, 0, 0));
    cyc(1, 4'd0, 4'd3, 0);
    check("stalled", ex(0, 0, 0, 4'hf, 8'd4, 0, 1));
    do_reset();
    cyc(1, 4'd5, 4'd5, 0);
    check("post_reset_capture", ex(0, 0, 0, 4'h0, 8'd0, 0, 0));
    repeat (15) cyc(1, 4'd5, 4'd6, 0);
    check("stall_again", ex(0, 0, 0, 4'h0, 8'd0, 0, 1));
    cyc(1, 4'd6, 4'd6, 0);
    check("stall_exit_match", ex(0, 1, 0, 4'h0, 8'd0, 0, 0));
    cyc(1, 4'd7, 4'd6, 0);
    check("after_exit", ex(0, 0, 0, 4'h0, 8'd0, 0, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
